palette_lookup_arbiter: RTL and testbench
=========================================

# palette_lookup_arbiter

Round-robin arbiter that shares one combinational 16-entry sprite palette between several sprite renderers (player 1, player 2, ball, background). Each renderer presents a 4-bit colour index with a valid/ready handshake. The block serialises lookups onto the single palette port, registers the 12-bit RGB result and returns it tagged with the requester ID. It sits between the per-sprite ROM readers and the pixel compositor in the VGA path.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8)
- IDX_W, 4: palette index width
- CH_W, 4: bits per colour channel
- TRANSPARENT_IDX, 0: index treated as transparent (used only with the config macro)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester lookup request
- req_index  in  NUM_REQ×IDX_W  per-requester colour index
- req_ready  out  NUM_REQ  one-hot-or-zero accept strobe
- pal_index  out  IDX_W  index driven to the shared palette
- pal_red, pal_green, pal_blue  in  CH_W each  palette result for pal_index, combinational, same cycle
- resp_valid  out  1  response available
- resp_ready  in  1  compositor accepts response
- resp_id  out  $clog2(NUM_REQ)  requester that issued the lookup
- resp_rgb  out  3×CH_W  {red,green,blue}
- resp_transparent  out  1  present only with PAL_ARB_TRANSPARENT_EN

## Operation
- Two pipeline stages:
  - A holds a_valid, a_id and a_index; a_index drives pal_index.
  - B holds resp_valid, resp_id, resp_rgb and captures the palette outputs.
- Advance rules:
  - b_adv = !resp_valid || resp_ready
  - a_adv = !a_valid || b_adv
- Grant is combinational, round-robin from pointer rr_ptr. It picks the first i with req_valid[i], scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
- req_ready[i] = a_adv && grant[i]. At most one bit is high. Ready is zero when no request is valid.
- On acceptance (valid & ready):
  - A loads the index and ID, and sets a_valid.
  - rr_ptr ← granted+1, wrapping to 0 after NUM_REQ-1.
- When a_adv is high and nothing is accepted, a_valid ← 0.
- When b_adv is high, B loads from A: resp_valid ← a_valid, with rgb and id.
- When b_adv is low, both stages hold.
- Requesters hold req_valid and req_index stable until accepted. req_valid must not depend on req_ready.
- With a single active requester, that requester is granted every cycle.

## Timing
- Reset (async assert, synchronous-safe release) sets:
  - rr_ptr=0, a_valid=0, a_id=0, a_index=0, so pal_index=0
  - resp_valid=0, resp_id=0, resp_rgb=0, resp_transparent=0
  - req_ready follows a_adv=1, so it can be high in the first cycle after reset.
- Latency: accepted in cycle T, pal_index valid in T+1, resp_valid high from T+2.
- Throughput is one lookup per cycle when resp_ready is held high.
- Backpressure (resp_ready low while resp_valid is high):
  - B holds.
  - A holds if it is full.
  - All req_ready are 0 while A is full; rr_ptr does not move.
- At most 2 lookups are in flight. No response is dropped or duplicated across a stall.
- Reset asserted mid-operation discards both stages immediately, with no response emitted.

## Configuration
- PAL_ARB_TRANSPARENT_EN defined:
  - The resp_transparent port exists.
  - Stage A also registers (index == TRANSPARENT_IDX). It is presented with the response.
  - resp_rgb is forced to 0 for transparent entries.
- Undefined: the port is absent and resp_rgb is always the palette value.

## Structure
- Package palette_arb_pkg holds:
  - IDX_W and CH_W defaults
  - typedef rgb_t (packed 3×CH_W)
  - typedef pal_req_t {index}
- Sub-module palette_rr_grant: purely combinational.
  - Inputs: req_valid, rr_ptr.
  - Outputs: one-hot grant, granted id, any_grant.
  - The pointer register stays in the parent.

## Test plan
- Single requester: req_valid[1]=1 with index 4, resp_ready=1. resp_valid at T+2, resp_id=1, resp_rgb=12'h985. A new lookup is accepted every cycle.
- All four requesters valid continuously from reset. Grant order is 0,1,2,3,0,1… and each id appears once per 4 responses.
- Backpressure: resp_ready=0 for 5 cycles with two lookups in flight. req_ready is all-zero, resp data is stable, rr_ptr is unchanged. After release, both responses arrive in order with no loss.
- Requesters 0 and 2 valid, rr_ptr=1. Grant goes to 2, then 0, then 2.
- Reset pulsed low mid-stream with 2 lookups in flight. resp_valid=0 and pal_index=0 immediately. After release, the first grant goes to the lowest valid requester.
- With PAL_ARB_TRANSPARENT_EN, index 0 gives resp_transparent=1 and resp_rgb=0. Index 10 gives resp_transparent=0 and resp_rgb=12'hFFF.

Source files
------------

// File: rtl/palette_arb_pkg.sv
// Shared defaults and types for the palette lookup arbiter.
package palette_arb_pkg;

    localparam int IDX_W_DEF = 4;
    localparam int CH_W_DEF  = 4;

    typedef logic [3*CH_W_DEF-1:0] rgb_t;

    typedef struct packed {
        logic [IDX_W_DEF-1:0] index;
    } pal_req_t;

endpackage

// File: rtl/palette_rr_grant.sv
// Combinational round-robin grant: first valid requester at or after rr_ptr,
// modulo NUM_REQ. The pointer register lives in the parent.
module palette_rr_grant #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               any_grant
);

    logic [ID_W:0] w_ptr;
    logic [ID_W:0] w_pos;
    logic [ID_W:0] w_dist;
    logic [ID_W:0] w_best;

    // Each requester's distance from the pointer; the smallest valid one wins.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_ptr     = {1'b0, rr_ptr};
        w_pos     = '0;
        w_dist    = '0;
        w_best    = '1;
        grant_id  = '0;
        any_grant = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_pos  = (ID_W+1)'(i);
            w_dist = (w_pos >= w_ptr) ? (w_pos - w_ptr)
                                      : (w_pos + (ID_W+1)'(NUM_REQ) - w_ptr);
            if (req_valid[i] && (w_dist < w_best)) begin
                w_best    = w_dist;
                grant_id  = ID_W'(i);
                any_grant = 1'b1;
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = any_grant && (grant_id == ID_W'(i));
        end
    end

endmodule

// File: rtl/palette_lookup_arbiter.sv
// Round-robin arbiter sharing one combinational palette between renderers.
// Optional feature macro: PAL_ARB_TRANSPARENT_EN (transparent-index flag).
module palette_lookup_arbiter
    import palette_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int CH_W    = CH_W_DEF
`ifdef PAL_ARB_TRANSPARENT_EN
    ,
    parameter int TRANSPARENT_IDX = 0
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*IDX_W-1:0]   req_index,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [IDX_W-1:0]           pal_index,
    input  logic [CH_W-1:0]            pal_red,
    input  logic [CH_W-1:0]            pal_green,
    input  logic [CH_W-1:0]            pal_blue,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [3*CH_W-1:0]          resp_rgb
`ifdef PAL_ARB_TRANSPARENT_EN
    ,
    output logic                       resp_transparent
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]    r_rr_ptr;
    logic               r_a_valid;
    logic [ID_W-1:0]    r_a_id;
    logic [IDX_W-1:0]   r_a_index;
    logic               r_resp_valid;
    logic [ID_W-1:0]    r_resp_id;
    logic [3*CH_W-1:0]  r_resp_rgb;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_id;
    logic               w_any_grant;
    logic               w_b_adv;
    logic               w_a_adv;
    logic               w_accept;
    logic [IDX_W-1:0]   w_sel_index;
    logic [3*CH_W-1:0]  w_pal_rgb;

    palette_rr_grant #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_grant (
        .req_valid (req_valid),
        .rr_ptr    (r_rr_ptr),
        .grant     (w_grant),
        .grant_id  (w_grant_id),
        .any_grant (w_any_grant)
    );

    assign w_b_adv   = !r_resp_valid || resp_ready;
    assign w_a_adv   = !r_a_valid || w_b_adv;
    assign w_accept  = w_a_adv && w_any_grant;
    assign req_ready = w_a_adv ? w_grant : '0;
    assign w_pal_rgb = {pal_red, pal_green, pal_blue};

    always_comb begin
        w_sel_index = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) w_sel_index = req_index[i*IDX_W +: IDX_W];
        end
    end

`ifdef PAL_ARB_TRANSPARENT_EN
    logic r_a_transp;
    logic r_resp_transparent;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr     <= '0;
            r_a_valid    <= 1'b0;
            r_a_id       <= '0;
            r_a_index    <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_rgb   <= '0;
`ifdef PAL_ARB_TRANSPARENT_EN
            r_a_transp         <= 1'b0;
            r_resp_transparent <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so stage B samples stage A's pre-edge contents.
            if (w_a_adv) begin
                r_a_valid <= w_accept;
                if (w_accept) begin
                    r_a_id    <= w_grant_id;
                    r_a_index <= w_sel_index;
                    r_rr_ptr  <= (w_grant_id == ID_W'(NUM_REQ-1)) ? '0
                                                                  : w_grant_id + 1'b1;
`ifdef PAL_ARB_TRANSPARENT_EN
                    r_a_transp <= (w_sel_index == IDX_W'(TRANSPARENT_IDX));
`endif
                end
            end
            if (w_b_adv) begin
                r_resp_valid <= r_a_valid;
                r_resp_id    <= r_a_id;
`ifdef PAL_ARB_TRANSPARENT_EN
                r_resp_rgb         <= r_a_transp ? '0 : w_pal_rgb;
                r_resp_transparent <= r_a_transp;
`else
                r_resp_rgb   <= w_pal_rgb;
`endif
            end
        end
    end

    assign pal_index  = r_a_index;
    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_rgb   = r_resp_rgb;
`ifdef PAL_ARB_TRANSPARENT_EN
    assign resp_transparent = r_resp_transparent;
`endif

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Self-checking bench: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_palette_lookup_arbiter;
    import palette_arb_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req_valid;
    logic [15:0]  req_index;
    logic [N-1:0] req_ready;
    logic [3:0]   pal_index;
    logic [3:0]   pal_red, pal_green, pal_blue;
    logic         resp_valid;
    logic         resp_ready;
    logic [1:0]   resp_id;
    logic [11:0]  resp_rgb;
`ifdef PAL_ARB_TRANSPARENT_EN
    logic         resp_transparent;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    palette_lookup_arbiter #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_index  (req_index),
        .req_ready  (req_ready),
        .pal_index  (pal_index),
        .pal_red    (pal_red),
        .pal_green  (pal_green),
        .pal_blue   (pal_blue),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_rgb   (resp_rgb)
`ifdef PAL_ARB_TRANSPARENT_EN
        ,
        .resp_transparent (resp_transparent)
`endif
    );

    function automatic rgb_t pal_of(input logic [3:0] i);
        case (i)
            4'd0:  return 12'h123;
            4'd1:  return 12'h456;
            4'd2:  return 12'h789;
            4'd3:  return 12'hABC;
            4'd4:  return 12'h985;
            4'd5:  return 12'h111;
            4'd6:  return 12'h222;
            4'd7:  return 12'h333;
            4'd8:  return 12'h444;
            4'd9:  return 12'h555;
            4'd10: return 12'hFFF;
            4'd11: return 12'h666;
            4'd12: return 12'h777;
            4'd13: return 12'h888;
            4'd14: return 12'h999;
            default: return 12'hAAA;
        endcase
    endfunction

    assign {pal_red, pal_green, pal_blue} = pal_of(pal_index);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Leaves the bench at a falling edge with reset just released.
    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = '0;
        req_index  = '0;
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] valid;
        logic [15:0]  idx;
        logic         rready;
        logic [N-1:0] exp_ready;
        logic         exp_rv;
        logic [1:0]   exp_id;
        rgb_t         exp_rgb;
    } vec_t;

    vec_t tbl[11];

    typedef struct {
        logic [1:0] id;
        rgb_t       rgb;
    } item_t;

    item_t        exp_q[$];
    int           m_ptr;
    bit           m_rv[N];
    logic [3:0]   m_idx[N];

    // One cycle of randomized traffic checked against the in-flight queue.
    task automatic rand_cycle(input bit allow_new, input bit force_ready);
        int           g;
        int           j;
        bit           allow;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (allow_new && !m_rv[i] && ($urandom_range(0, 99) < 40)) begin
                m_rv[i]  = 1'b1;
                m_idx[i] = 4'($urandom_range(0, 15));
            end
            req_valid[i]         = m_rv[i];
            req_index[i*4 +: 4]  = m_idx[i];
        end
        resp_ready = force_ready ? 1'b1 : ($urandom_range(0, 99) < 70);
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (m_rv[j] && g < 0) g = j;
        end
        // Two slots: with both full, a new lookup fits only if one leaves now.
        allow     = (exp_q.size() < 2) || resp_ready;
        exp_ready = (g >= 0 && allow) ? N'(1 << g) : '0;
        check("rand_ready", 32'(req_ready), 32'(exp_ready));
        if (resp_valid) begin
            check("rand_resp_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                check("rand_resp_id", 32'(resp_id), 32'(exp_q[0].id));
                check("rand_resp_rgb", 32'(resp_rgb), 32'(exp_q[0].rgb));
            end
        end
        if (resp_valid && resp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (exp_ready != '0) begin
            exp_q.push_back('{id: 2'(g), rgb: pal_of(m_idx[g])});
            m_rv[g] = 1'b0;
            m_ptr   = (g + 1) % N;
        end
    endtask

    initial begin
        rgb_t held_rgb;

        tbl[0]  = '{4'b0010, 16'h0040, 1'b1, 4'b0010, 1'b0, 2'd0, 12'h000};
        tbl[1]  = '{4'b0010, 16'h0040, 1'b1, 4'b0010, 1'b0, 2'd0, 12'h000};
        tbl[2]  = '{4'b0010, 16'h0040, 1'b1, 4'b0010, 1'b1, 2'd1, 12'h985};
        tbl[3]  = '{4'b0010, 16'h0040, 1'b1, 4'b0010, 1'b1, 2'd1, 12'h985};
        tbl[4]  = '{4'b0001, 16'h0003, 1'b1, 4'b0001, 1'b1, 2'd1, 12'h985};
        tbl[5]  = '{4'b0101, 16'h0605, 1'b1, 4'b0100, 1'b1, 2'd1, 12'h985};
        tbl[6]  = '{4'b0101, 16'h0605, 1'b1, 4'b0001, 1'b1, 2'd0, 12'hABC};
        tbl[7]  = '{4'b0101, 16'h0605, 1'b1, 4'b0100, 1'b1, 2'd2, 12'h222};
        tbl[8]  = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 2'd0, 12'h111};
        tbl[9]  = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 2'd2, 12'h222};
        tbl[10] = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 2'd0, 12'h000};

        // Reset state.
        do_reset();
        #1;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_pal_index", 32'(pal_index), 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_resp_rgb", 32'(resp_rgb), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);

        // Directed table: single requester, then requesters 0/2 from rr_ptr=1.
        do_reset();
        for (int r = 0; r < 11; r++) begin
            req_valid  = tbl[r].valid;
            req_index  = tbl[r].idx;
            resp_ready = tbl[r].rready;
            #1;
            check($sformatf("tbl%0d_ready", r), 32'(req_ready), 32'(tbl[r].exp_ready));
            check($sformatf("tbl%0d_rv", r), 32'(resp_valid), 32'(tbl[r].exp_rv));
            if (tbl[r].exp_rv) begin
                check($sformatf("tbl%0d_id", r), 32'(resp_id), 32'(tbl[r].exp_id));
                check($sformatf("tbl%0d_rgb", r), 32'(resp_rgb), 32'(tbl[r].exp_rgb));
            end
            @(negedge clk);
        end

        // All four requesters continuously valid from reset.
        do_reset();
        req_valid = 4'hF;
        req_index = 16'h4321;
        for (int c = 0; c < 14; c++) begin
            #1;
            check("rr4_ready", 32'(req_ready), 32'(1 << (c % 4)));
            if (c >= 2) begin
                check("rr4_rv", 32'(resp_valid), 32'd1);
                check("rr4_id", 32'(resp_id), 32'((c - 2) % 4));
                check("rr4_rgb", 32'(resp_rgb), 32'(pal_of(4'(((c - 2) % 4) + 1))));
            end
            @(negedge clk);
        end

        // Backpressure with two lookups in flight.
        do_reset();
        req_valid = 4'b0001;
        req_index = 16'h0987;
        #1;
        check("bp_acc0", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        check("bp_acc1", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid  = 4'b1101;
        resp_ready = 1'b0;
        held_rgb   = pal_of(4'd7);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_ready_zero", 32'(req_ready), 32'd0);
            check("bp_rv_hold", 32'(resp_valid), 32'd1);
            check("bp_id_hold", 32'(resp_id), 32'd0);
            check("bp_rgb_hold", 32'(resp_rgb), 32'(held_rgb));
            check("bp_a_hold", 32'(pal_index), 32'd8);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'b0100);
        check("bp_out0_id", 32'(resp_id), 32'd0);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("bp_out1_rv", 32'(resp_valid), 32'd1);
        check("bp_out1_id", 32'(resp_id), 32'd1);
        check("bp_out1_rgb", 32'(resp_rgb), 32'(pal_of(4'd8)));
        @(negedge clk);
        #1;
        check("bp_out2_id", 32'(resp_id), 32'd2);
        check("bp_out2_rgb", 32'(resp_rgb), 32'(pal_of(4'd9)));
        @(negedge clk);
        #1;
        check("bp_drained", 32'(resp_valid), 32'd0);

        // Reset mid-stream discards both stages.
        do_reset();
        req_valid = 4'hF;
        req_index = 16'h5555;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rv", 32'(resp_valid), 32'd0);
        check("mid_rst_pal", 32'(pal_index), 32'd0);
        @(negedge clk);
        req_valid = 4'b1010;
        rst_n     = 1'b1;
        #1;
        check("mid_rst_first_grant", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid = '0;

`ifdef PAL_ARB_TRANSPARENT_EN
        do_reset();
        req_valid = 4'b0001;
        req_index = 16'h00A0;
        @(negedge clk);
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = '0;
        #1;
        check("tr0_flag", 32'(resp_transparent), 32'd1);
        check("tr0_rgb", 32'(resp_rgb), 32'd0);
        @(negedge clk);
        #1;
        check("tr10_flag", 32'(resp_transparent), 32'd0);
        check("tr10_rgb", 32'(resp_rgb), 32'hFFF);
`endif

        // Randomized traffic against the reference model.
        do_reset();
        m_ptr = 0;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            m_rv[i]  = 1'b0;
            m_idx[i] = '0;
        end
        for (int c = 0; c < 400; c++) rand_cycle(1'b1, 1'b0);
        for (int c = 0; c < 12; c++) rand_cycle(1'b0, 1'b1);
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check("drain_rv_low", 32'(resp_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
